// File: rtl/cdma_tx_ctrl.sv
// Transmit sequencer for the CDMA spreader: captures a word and seed on start,
// strobes the seed load, then serializes the word MSB-first at a fixed chip rate.
`timescale 1ns/1ps

module cdma_tx_ctrl #(
   parameter int CHIP_DIV      = 4,
   parameter int CHIPS_PER_BIT = 31,
   parameter int DATA_W        = 8
) (
   input  logic                                        clk_i,
   input  logic                                        rst_ni,
   input  logic                                        start_i,
   input  logic [DATA_W-1:0]                           data_i,
   input  logic [4:0]                                  seed_i,
   input  logic                                        abort_i,
   output logic                                        load_o,
   output logic [4:0]                                  seed_o,
   output logic                                        signal_o,
   output logic                                        chip_en_o,
   output logic                                        busy_o,
   output logic                                        done_o,
   output logic [((DATA_W > 1) ? $clog2(DATA_W) : 1)-1:0] bit_idx_o
);

   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int CW = (CHIPS_PER_BIT > 1) ? $clog2(CHIPS_PER_BIT) : 1;
   localparam int PW = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(CHIP_DIV - 1);
   localparam logic [CW-1:0] CHIP_LAST  = CW'(CHIPS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_W - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_GUARD = 3'd2;
   localparam logic [2:0] S_SEND  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]        state;
   logic [DATA_W-1:0] data_reg;
   logic [4:0]        seed_reg;
   logic [PW-1:0]     presc;
   logic [CW-1:0]     chip_cnt;
   logic [BW-1:0]     bit_cnt;

   logic          chip_tick;
   logic [BW-1:0] cur_idx;

   // Counters only ever hold non-zero values in SEND; every exit from SEND clears
   // them, so bit_idx_o naturally reads 0 in all other states.
   assign chip_tick = (state == S_SEND) && (presc == PRESC_LAST);
   assign cur_idx   = BIT_LAST - bit_cnt;

   assign load_o    = (state == S_LOAD);
   assign seed_o    = (state == S_LOAD) ? seed_reg : 5'd0;
   assign signal_o  = (state == S_SEND) && data_reg[cur_idx];
   assign chip_en_o = chip_tick;
   assign busy_o    = (state != S_IDLE);
   assign done_o    = (state == S_DONE);
   assign bit_idx_o = bit_cnt;

   // NOTE: all state below uses non-blocking assignments so every register samples
   // the pre-edge values of its peers, independent of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= S_IDLE;
         data_reg <= '0;
         seed_reg <= '0;
         presc    <= '0;
         chip_cnt <= '0;
         bit_cnt  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  data_reg <= data_i;
                  seed_reg <= seed_i;
                  state    <= S_LOAD;
               end
            end
            S_LOAD: state <= abort_i ? S_IDLE : S_GUARD;
            S_GUARD: begin
               presc    <= '0;
               chip_cnt <= '0;
               bit_cnt  <= '0;
               state    <= abort_i ? S_IDLE : S_SEND;
            end
            S_SEND: begin
               if (abort_i) begin
                  presc    <= '0;
                  chip_cnt <= '0;
                  bit_cnt  <= '0;
                  state    <= S_IDLE;
               end else begin
                  presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
                  if (chip_tick) begin
                     if (chip_cnt == CHIP_LAST) begin
                        chip_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                           bit_cnt <= '0;
                           presc   <= '0;
                           state   <= S_DONE;
                        end else begin
                           bit_cnt <= bit_cnt + 1'b1;
                        end
                     end else begin
                        chip_cnt <= chip_cnt + 1'b1;
                     end
                  end
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cdma_tx_ctrl.sv
// Directed self-checking bench for cdma_tx_ctrl: default configuration plus a
// small CHIP_DIV=1 / CHIPS_PER_BIT=3 / DATA_W=4 instance.
`timescale 1ns/1ps

module tb_cdma_tx_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       start = 1'b0, abort = 1'b0;
   logic [7:0] data = '0;
   logic [4:0] seed = '0;
   logic       load_o, signal_o, chip_en_o, busy_o, done_o;
   logic [4:0] seed_o;
   logic [2:0] bit_idx_o;

   logic       b_start = 1'b0, b_abort = 1'b0;
   logic [3:0] b_data = '0;
   logic [4:0] b_seed = '0;
   logic       b_load, b_signal, b_chip_en, b_busy, b_done;
   logic [4:0] b_seed_o;
   logic [1:0] b_bit_idx;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cdma_tx_ctrl dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .data_i(data), .seed_i(seed),
      .abort_i(abort), .load_o(load_o), .seed_o(seed_o), .signal_o(signal_o),
      .chip_en_o(chip_en_o), .busy_o(busy_o), .done_o(done_o), .bit_idx_o(bit_idx_o)
   );

   cdma_tx_ctrl #(.CHIP_DIV(1), .CHIPS_PER_BIT(3), .DATA_W(4)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .start_i(b_start), .data_i(b_data), .seed_i(b_seed),
      .abort_i(b_abort), .load_o(b_load), .seed_o(b_seed_o), .signal_o(b_signal),
      .chip_en_o(b_chip_en), .busy_o(b_busy), .done_o(b_done), .bit_idx_o(b_bit_idx)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] outs_a();
      return 32'({load_o, seed_o, signal_o, chip_en_o, busy_o, done_o, bit_idx_o});
   endfunction

   function automatic logic [31:0] outs_b();
      return 32'({b_load, b_seed_o, b_signal, b_chip_en, b_busy, b_done, b_bit_idx});
   endfunction

   // Present a start pulse; the edge that accepts it is "edge 0".
   task automatic kick(input logic [7:0] d, input logic [4:0] s);
      @(negedge clk);
      data  = d;
      seed  = s;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Observe cycles 1..1000 after edge 0 and check the whole default-config frame.
   // With hold=1, start stays high and data changes to 8'hFF mid-frame.
   task automatic run_frame(input string tag, input logic [7:0] exp_d,
                            input logic [4:0] exp_seed, input bit hold);
      int n_load = 0, load_c0 = 0, load_c1 = 0, n_chip = 0, chip_bad = 0;
      int sig_bad = 0, idx_bad = 0, busy_bad = 0, n_done = 0, done_c = 0;
      logic [4:0] seed_seen = '0;
      for (int cyc = 1; cyc <= 1000; cyc++) begin
         bit   in_send;
         int   b;
         logic exp_sig, exp_chip, exp_busy;
         @(negedge clk);
         in_send  = (cyc >= 3) && (cyc <= 994);
         b        = in_send ? (cyc - 3) / 124 : 0;
         exp_sig  = in_send ? exp_d[7 - b] : 1'b0;
         exp_chip = in_send && ((cyc - 3) % 4 == 3);
         exp_busy = (cyc <= 995) || (hold && cyc >= 997);
         if (load_o) begin
            if (n_load == 0) begin
               load_c0   = cyc;
               seed_seen = seed_o;
            end else begin
               load_c1 = cyc;
            end
            n_load++;
         end
         if (cyc <= 998 && signal_o !== exp_sig) sig_bad++;
         if (cyc <= 998 && bit_idx_o !== 3'(b)) idx_bad++;
         if (chip_en_o) n_chip++;
         if (chip_en_o !== exp_chip) chip_bad++;
         if (done_o) begin
            n_done++;
            done_c = cyc;
         end
         if (busy_o !== exp_busy) busy_bad++;
         if (hold && cyc == 500) data = 8'hFF;
      end
      check({tag, "_load_count"}, n_load, hold ? 2 : 1);
      check({tag, "_load_cycle"}, load_c0, 1);
      check({tag, "_seed"}, 32'(seed_seen), 32'(exp_seed));
      if (hold) check({tag, "_reload_cycle"}, load_c1, 997);
      check({tag, "_chip_en_count"}, n_chip, 248);
      check({tag, "_chip_en_pattern_errs"}, chip_bad, 0);
      check({tag, "_signal_errs"}, sig_bad, 0);
      check({tag, "_bit_idx_errs"}, idx_bad, 0);
      check({tag, "_done_count"}, n_done, 1);
      check({tag, "_done_cycle"}, done_c, 995);
      check({tag, "_busy_errs"}, busy_bad, 0);
   endtask

   initial begin
      logic [11:0] exp_b_sig;
      int          n_done_seen;

      // Reset held with random inputs.
      data  = 8'($urandom);
      seed  = 5'($urandom);
      start = 1'b1;
      abort = 1'($urandom);
      b_start = 1'b1;
      b_data  = 4'($urandom);
      repeat (3) @(negedge clk);
      check("reset_outs_a", outs_a(), 0);
      check("reset_outs_b", outs_b(), 0);
      start   = 1'b0;
      abort   = 1'b0;
      b_start = 1'b0;
      #2 rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check($sformatf("idle_outs_%0d", i), outs_a(), 0);
      end

      // Nominal frame, default configuration.
      kick(8'hA5, 5'h13);
      run_frame("frame_a5", 8'hA5, 5'h13, 1'b0);

      // Busy lockout: start held high, data changed mid-frame.
      kick(8'hA5, 5'h0E);
      start = 1'b1;
      run_frame("lockout", 8'hA5, 5'h0E, 1'b1);
      start = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("lockout_abort_busy", busy_o, 0);

      // Abort at bit 3, chip 10 (cycle 3 + (3*31+10)*4 = 415).
      kick(8'hC3, 5'h07);
      repeat (415) @(negedge clk);
      check("abort_pre_bit_idx", bit_idx_o, 3);
      check("abort_pre_busy", busy_o, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", busy_o, 0);
      check("abort_signal", signal_o, 0);
      check("abort_chip_en", chip_en_o, 0);
      n_done_seen = 0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (done_o || busy_o) n_done_seen++;
      end
      check("abort_no_done", n_done_seen, 0);
      kick(8'h3C, 5'h01);
      run_frame("after_abort", 8'h3C, 5'h01, 1'b0);

      // Asynchronous reset in bit 5 (cycles 623..746).
      kick(8'h5A, 5'h1F);
      repeat (650) @(negedge clk);
      check("rst_mid_pre_bit_idx", bit_idx_o, 5);
      #2 rst_n = 1'b0;
      #1 check("rst_mid_async_outs", outs_a(), 0);
      #7;
      #2 rst_n = 1'b1;
      n_done_seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (outs_a() != 0) n_done_seen++;
      end
      check("rst_mid_stays_idle", n_done_seen, 0);
      kick(8'h96, 5'h0B);
      run_frame("after_reset", 8'h96, 5'h0B, 1'b0);

      // Small config; start and abort together in IDLE: start wins.
      exp_b_sig = 12'b1110_0000_0111;
      @(negedge clk);
      b_data  = 4'b1001;
      b_seed  = 5'h05;
      b_start = 1'b1;
      b_abort = 1'b1;
      @(posedge clk);
      #1;
      b_start = 1'b0;
      b_abort = 1'b0;
      for (int cyc = 1; cyc <= 16; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            check("b_load", b_load, 1);
            check("b_seed", b_seed_o, 5'h05);
         end else if (cyc >= 3 && cyc <= 14) begin
            check($sformatf("b_chip_en_c%0d", cyc), b_chip_en, 1);
            check($sformatf("b_signal_c%0d", cyc), b_signal, exp_b_sig[11 - (cyc - 3)]);
         end else if (cyc == 15) begin
            check("b_done", b_done, 1);
            check("b_chip_en_done", b_chip_en, 0);
         end else if (cyc == 16) begin
            check("b_idle_busy", b_busy, 0);
            check("b_idle_done", b_done, 0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
